// File: rtl/uart_tagged_in_mux.sv
// uart_tagged_in_mux
// Merges UART_COUNT first-word-fall-through RX FIFOs into one host TX FIFO.
// Each grant emits TAG_BYTE followed by the channel number, then up to
// MAX_BURST data bytes. A data byte equal to TAG_BYTE is sent twice so the
// host can tell it apart from a channel switch. Arbitration is round-robin
// and respects a per-channel enable mask.
module uart_tagged_in_mux #(
    parameter int unsigned           DATA_BITS  = 8,
    parameter int unsigned           UART_COUNT = 4,
    parameter int unsigned           MAX_BURST  = 16,
    parameter int unsigned           BURST_BITS = 8,
    parameter logic [DATA_BITS-1:0]  TAG_BYTE   = 8'hFE,
    localparam int unsigned          GRANT_BITS = (UART_COUNT > 1) ? $clog2(UART_COUNT) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_COUNT-1:0]           enable,
    input  logic [UART_COUNT-1:0]           empty,
    input  logic [UART_COUNT*DATA_BITS-1:0] data,
    output logic [UART_COUNT-1:0]           read,
    input  logic                            fifo_full,
    output logic                            fifo_write,
    output logic [DATA_BITS-1:0]            fifo_data,
    output logic                            busy,
    output logic [GRANT_BITS-1:0]           grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_CHAN,
        S_DATA,
        S_STUFF
    } state_t;

    state_t                  state_q, state_d;
    logic [GRANT_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRANT_BITS-1:0]   grant_q, grant_d;
    logic [BURST_BITS-1:0]   count_q, count_d;

    logic                    scan_found;
    logic [GRANT_BITS-1:0]   scan_idx;
    logic [GRANT_BITS-1:0]   scan_cand;
    logic [GRANT_BITS-1:0]   next_ptr;
    logic [DATA_BITS-1:0]    head_data;
    logic                    head_empty;
    logic                    head_enable;
    logic                    burst_done;

    // (base + off) modulo UART_COUNT; both operands are below UART_COUNT.
    function automatic logic [GRANT_BITS-1:0] wrap_add(
        input logic [GRANT_BITS-1:0] base,
        input int unsigned           off
    );
        int unsigned s;
        s = 32'(base) + off;
        if (s >= UART_COUNT) begin
            s = s - UART_COUNT;
        end
        return GRANT_BITS'(s);
    endfunction

    // Rotating scan from rr_ptr for the first enabled, non-empty channel.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_cand  = '0;
        for (int unsigned k = 0; k < UART_COUNT; k++) begin
            scan_cand = wrap_add(rr_ptr_q, k);
            if (!scan_found && !empty[scan_cand] && enable[scan_cand]) begin
                scan_found = 1'b1;
                scan_idx   = scan_cand;
            end
        end
    end

    // View of the currently granted channel.
    always_comb begin
        head_data   = data[32'(grant_q) * DATA_BITS +: DATA_BITS];
        head_empty  = empty[grant_q];
        head_enable = enable[grant_q];
        burst_done  = (count_q == BURST_BITS'(MAX_BURST));
        next_ptr    = wrap_add(grant_q, 1);
    end

    // Next-state and strobe generation; push and pop share one cycle.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        count_d    = count_q;
        read       = '0;
        fifo_write = 1'b0;
        fifo_data  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (scan_found) begin
                    grant_d = scan_idx;
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                if (!fifo_full) begin
                    fifo_write = 1'b1;
                    fifo_data  = TAG_BYTE;
                    state_d    = S_CHAN;
                end
            end
            S_CHAN: begin
                if (!fifo_full) begin
                    fifo_write = 1'b1;
                    fifo_data  = DATA_BITS'(grant_q);
                    count_d    = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // Burst end is checked before backpressure so a drained or
                // masked channel releases the grant even while the host is full.
                if (head_empty || !head_enable || burst_done) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!fifo_full) begin
                    fifo_write     = 1'b1;
                    fifo_data      = head_data;
                    read[grant_q]  = 1'b1;
                    count_d        = count_q + 1'b1;
                    if (head_data == TAG_BYTE) begin
                        state_d = S_STUFF;
                    end
                end
            end
            S_STUFF: begin
                if (!fifo_full) begin
                    fifo_write = 1'b1;
                    fifo_data  = TAG_BYTE;
                    state_d    = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
        end
    end

    // Status outputs straight from the registers.
    always_comb begin
        busy  = (state_q != S_IDLE);
        grant = grant_q;
    end

endmodule

// File: tb/tb_uart_tagged_in_mux.sv
// Bench for uart_tagged_in_mux: source FIFOs and host stream kept as queues,
// a queue-based behavioural model predicts every cycle's strobes.
module tb_uart_tagged_in_mux;

    localparam int         NCH  = 4;
    localparam int         DW   = 8;
    localparam int         MAXB = 16;
    localparam logic [7:0] TAG  = 8'hFE;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    enable;
    logic [NCH-1:0]    empty;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    read;
    logic              fifo_full;
    logic              fifo_write;
    logic [DW-1:0]     fifo_data;
    logic              busy;
    logic [1:0]        grant;

    always #5 clk = ~clk;

    uart_tagged_in_mux #(
        .DATA_BITS (8),
        .UART_COUNT(4),
        .MAX_BURST (16),
        .BURST_BITS(8),
        .TAG_BYTE  (8'hFE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .empty     (empty),
        .data      (data),
        .read      (read),
        .fifo_full (fifo_full),
        .fifo_write(fifo_write),
        .fifo_data (fifo_data),
        .busy      (busy),
        .grant     (grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src [NCH][$];
    logic [7:0] pend[$];
    logic [7:0] host[$];
    int         rd_cnt[NCH];
    int         busy_cycles;
    int         g1_cycles;
    int         hold;

    // model state
    bit m_active;
    int m_grant, m_count, m_rr;
    // expectations for the current cycle
    bit             e_write, e_busy;
    logic [7:0]     e_data;
    logic [NCH-1:0] e_read;
    int             e_grant;
    // updates to apply after the clock edge
    bit u_start, u_pend_pop, u_stuff, u_end;
    int u_grant, u_pop_ch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hbyte(input int i);
        if (i < host.size()) return 32'(host[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit model_done();
        if (m_active) return 1'b0;
        for (int c = 0; c < NCH; c++)
            if (src[c].size() > 0 && enable[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            empty[c] = (src[c].size() == 0);
            data[c*DW +: DW] = empty[c] ? 8'($urandom) : src[c][0];
        end
    endtask

    // Model: a burst is a header queued on grant, then data bytes pulled one
    // per free host slot, each TAG data byte queuing one extra TAG.
    task automatic model_eval();
        e_write = 0; e_data = '0; e_read = '0; e_busy = m_active; e_grant = m_grant;
        u_start = 0; u_pend_pop = 0; u_stuff = 0; u_end = 0; u_grant = m_grant; u_pop_ch = -1;
        if (!m_active) begin
            for (int k = 0; k < NCH; k++) begin
                int c = (m_rr + k) % NCH;
                if (!u_start && src[c].size() > 0 && enable[c]) begin
                    u_start = 1; u_grant = c;
                end
            end
        end else if (pend.size() > 0) begin
            if (!fifo_full) begin e_write = 1; e_data = pend[0]; u_pend_pop = 1; end
        end else if (src[m_grant].size() == 0 || !enable[m_grant] || m_count == MAXB) begin
            u_end = 1;
        end else if (!fifo_full) begin
            e_write = 1; e_data = src[m_grant][0]; e_read[m_grant] = 1'b1;
            u_pop_ch = m_grant; u_stuff = (src[m_grant][0] == TAG);
        end
    endtask

    task automatic model_commit();
        if (u_pend_pop) void'(pend.pop_front());
        if (u_start) begin
            m_active = 1; m_grant = u_grant; m_count = 0;
            pend.push_back(TAG); pend.push_back(8'(u_grant));
        end
        if (u_pop_ch >= 0) begin
            void'(src[u_pop_ch].pop_front());
            m_count++;
            if (u_stuff) pend.push_back(TAG);
        end
        if (u_end) begin m_active = 0; m_rr = (m_grant + 1) % NCH; end
    endtask

    task automatic model_reset();
        m_active = 0; m_grant = 0; m_count = 0; m_rr = 0;
        pend.delete();
    endtask

    task automatic compare_outputs();
        chk("fifo_write", 32'(fifo_write), 32'(e_write));
        if (e_write) chk("fifo_data", 32'(fifo_data), 32'(e_data));
        chk("read", 32'(read), 32'(e_read));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_busy) chk("grant", 32'(grant), 32'(e_grant));
        if (fifo_write) host.push_back(fifo_data);
        for (int c = 0; c < NCH; c++) if (read[c]) rd_cnt[c]++;
        if (busy) busy_cycles++;
        if (busy && grant == 2'd1) g1_cycles++;
    endtask

    // One clock: drive, settle, compare, then advance past the edge.
    task automatic step();
        drive_inputs();
        #2;
        model_eval();
        compare_outputs();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) begin src[c].delete(); rd_cnt[c] = 0; end
        host.delete();
        busy_cycles = 0; g1_cycles = 0; hold = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // mode 0: host never full; 1: full held 5 cycles on a pending stuff; 2: random full
    task automatic run_idle(input int limit, input int mode);
        int n = 0;
        while (!model_done() && n < limit) begin
            case (mode)
                1: begin
                    fifo_full = (m_active && m_count > 0 && pend.size() > 0 && hold < 5);
                    if (fifo_full) hold++;
                end
                2: fifo_full = ($urandom_range(0, 2) == 0);
                default: fifo_full = 1'b0;
            endcase
            step();
            n++;
        end
        chk("drain_in_budget", 32'(model_done()), 32'd1);
        fifo_full = 1'b0;
        step();
        step();
    endtask

    logic [7:0] exp0[$];
    logic [7:0] exp3[$];
    logic [7:0] dec[$];

    initial begin
        int mism, n_fe, ch, n;
        logic [7:0] v;
        enable = '1; fifo_full = 1'b0; empty = '1; data = '0;
        clear_all();
        model_reset();

        // reset state
        #1 reset = 1'b1;
        #3;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_fifo_write", 32'(fifo_write), 32'd0);
        chk("rst_fifo_data", 32'(fifo_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single channel
        clear_all(); apply_reset();
        src[2].push_back(8'h41); src[2].push_back(8'h42);
        run_idle(50, 0);
        chk("t1_len", 32'(host.size()), 32'd4);
        chk("t1_b0", hbyte(0), 32'hFE);
        chk("t1_b1", hbyte(1), 32'h02);
        chk("t1_b2", hbyte(2), 32'h41);
        chk("t1_b3", hbyte(3), 32'h42);
        chk("t1_reads", 32'(rd_cnt[2]), 32'd2);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd5);

        // round robin with burst limit
        clear_all(); apply_reset();
        exp0.delete(); exp3.delete();
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom_range(0, 253)); src[0].push_back(v); exp0.push_back(v);
            v = 8'($urandom_range(0, 253)); src[3].push_back(v); exp3.push_back(v);
        end
        run_idle(300, 0);
        chk("t2_len", 32'(host.size()), 32'd48);
        chk("t2_h0a", hbyte(0), 32'hFE);  chk("t2_h0b", hbyte(1), 32'h00);
        chk("t2_h1a", hbyte(18), 32'hFE); chk("t2_h1b", hbyte(19), 32'h03);
        chk("t2_h2a", hbyte(36), 32'hFE); chk("t2_h2b", hbyte(37), 32'h00);
        chk("t2_h3a", hbyte(42), 32'hFE); chk("t2_h3b", hbyte(43), 32'h03);
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            if (hbyte(2 + i)  !== 32'(exp0[i])) mism++;
            if (hbyte(20 + i) !== 32'(exp3[i])) mism++;
        end
        for (int i = 0; i < 4; i++) begin
            if (hbyte(38 + i) !== 32'(exp0[16 + i])) mism++;
            if (hbyte(44 + i) !== 32'(exp3[16 + i])) mism++;
        end
        chk("t2_data_mismatches", 32'(mism), 32'd0);

        // stuffing, free-flowing then with the host full during the stuff
        for (int pass = 0; pass < 2; pass++) begin
            clear_all(); apply_reset();
            src[1].push_back(8'hFE); src[1].push_back(8'h10);
            run_idle(100, pass == 0 ? 0 : 1);
            chk("t3_len", 32'(host.size()), 32'd5);
            chk("t3_b0", hbyte(0), 32'hFE);
            chk("t3_b1", hbyte(1), 32'h01);
            chk("t3_b2", hbyte(2), 32'hFE);
            chk("t3_b3", hbyte(3), 32'hFE);
            chk("t3_b4", hbyte(4), 32'h10);
            chk("t3_reads", 32'(rd_cnt[1]), 32'd2);
        end
        chk("t3_hold_cycles", 32'(hold), 32'd5);

        // random backpressure on a 100-byte stream
        clear_all(); apply_reset();
        exp0.delete(); n_fe = 0;
        for (int i = 0; i < 100; i++) begin
            v = ($urandom_range(0, 7) == 0) ? TAG : 8'($urandom_range(0, 255));
            if (v == TAG) n_fe++;
            src[0].push_back(v); exp0.push_back(v);
        end
        run_idle(3000, 2);
        chk("t4_push_count", 32'(host.size()), 32'(100 + 14 + n_fe));
        chk("t4_pop_count", 32'(rd_cnt[0]), 32'd100);
        dec.delete(); ch = -1;
        for (int i = 0; i < host.size(); i++) begin
            if (host[i] == TAG && i + 1 < host.size()) begin
                if (host[i + 1] == TAG) begin
                    if (ch == 0) dec.push_back(TAG);
                end else begin
                    ch = int'(host[i + 1]);
                end
                i++;
            end else if (ch == 0) begin
                dec.push_back(host[i]);
            end
        end
        chk("t4_decoded_len", 32'(dec.size()), 32'd100);
        mism = 0;
        for (int i = 0; i < 100; i++)
            if (i >= dec.size() || dec[i] !== exp0[i]) mism++;
        chk("t4_stream_mismatches", 32'(mism), 32'd0);

        // enable mask
        clear_all(); apply_reset();
        enable = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            src[0].push_back(8'(8'h20 + i)); src[1].push_back(8'(8'h30 + i));
        end
        run_idle(200, 0);
        chk("t5_masked_grant_cycles", 32'(g1_cycles), 32'd0);
        chk("t5_masked_reads", 32'(rd_cnt[1]), 32'd0);
        chk("t5_ch0_reads", 32'(rd_cnt[0]), 32'd3);
        enable = 4'b1111;
        run_idle(200, 0);
        chk("t5_unmasked_reads", 32'(rd_cnt[1]), 32'd3);

        clear_all(); apply_reset();
        for (int i = 0; i < 10; i++) src[0].push_back(8'(8'h50 + i));
        n = 0;
        while (m_count < 3 && n < 50) begin fifo_full = 1'b0; step(); n++; end
        chk("t5_reached_mid_burst", 32'(m_count), 32'd3);
        enable = 4'b1110;
        run_idle(100, 0);
        chk("t5_stop_reads", 32'(rd_cnt[0]), 32'd3);
        chk("t5_left_in_fifo", 32'(src[0].size()), 32'd7);
        chk("t5_stop_len", 32'(host.size()), 32'd5);
        enable = 4'b1111;

        // asynchronous reset mid-burst
        clear_all(); apply_reset();
        exp0.delete();
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom_range(0, 253)); src[2].push_back(v); exp0.push_back(v);
        end
        n = 0;
        while (m_count < 4 && n < 50) begin fifo_full = 1'b0; step(); n++; end
        chk("t6_reached_data", 32'(m_count), 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("t6_read", 32'(read), 32'd0);
        chk("t6_fifo_write", 32'(fifo_write), 32'd0);
        chk("t6_fifo_data", 32'(fifo_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_grant", 32'(grant), 32'd0);
        model_reset();
        host.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        run_idle(100, 0);
        chk("t6_len", 32'(host.size()), 32'd8);
        chk("t6_h0", hbyte(0), 32'hFE);
        chk("t6_h1", hbyte(1), 32'h02);
        mism = 0;
        for (int i = 0; i < 6; i++) if (hbyte(2 + i) !== 32'(exp0[4 + i])) mism++;
        chk("t6_data_mismatches", 32'(mism), 32'd0);
        chk("t6_total_reads", 32'(rd_cnt[2]), 32'd10);

        // random traffic, enables and backpressure
        clear_all(); apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) begin
                int c = int'($urandom_range(0, NCH - 1));
                if (src[c].size() < 24)
                    src[c].push_back(($urandom_range(0, 7) == 0) ? TAG : 8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 19) == 0) enable[$urandom_range(0, NCH - 1)] ^= 1'b1;
            fifo_full = ($urandom_range(0, 2) == 0);
            step();
        end
        enable = '1;
        run_idle(5000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/uart_tagged_in_mux.md
Name: uart_tagged_in_mux

Overview:
- Parametrised successor to the plain UART input multiplexer.
- Merges the RX FIFOs of UART_COUNT serial channels into one host TX FIFO, which feeds the USB UART.
- Each burst is framed with an in-band tag so the host can tell which channel every byte came from. Any data byte equal to the tag value is escaped.
- Adds round-robin arbitration with a bounded burst length and a per-channel enable mask.

Parameters:
- DATA_BITS, 8, byte width of all data paths.
- UART_COUNT, 4, number of source channels. Legal range is 1..2^DATA_BITS-2.
- MAX_BURST, 16, maximum data bytes taken from one channel per grant. Must be at least 1.
- BURST_BITS, 8, width of the burst counter. Must satisfy 2^BURST_BITS > MAX_BURST.
- TAG_BYTE, 8'hFE, escape/tag value. Must be at least UART_COUNT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  UART_COUNT  per-channel enable mask. Bit i=1 allows channel i to be granted.
- empty  in  UART_COUNT  RX FIFO empty flags, one per channel.
- data  in  UART_COUNT*DATA_BITS  first-word-fall-through RX heads. Channel i occupies bits [i*DATA_BITS +: DATA_BITS].
- read  out  UART_COUNT  one-cycle pop strobes, one per channel.
- fifo_full  in  1  host TX FIFO full flag.
- fifo_write  out  1  one-cycle push strobe to the host FIFO.
- fifo_data  out  DATA_BITS  byte pushed to the host FIFO.
- busy  out  1  high whenever state is not IDLE.
- grant  out  clog2(UART_COUNT) (min 1)  index of the channel currently being served.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, grant=0, count=0.
  - read=0, fifo_write=0, fifo_data=0, busy=0.
- Output timing: read, fifo_write and fifo_data are combinational from the registered state/grant and the current fifo_full/empty/data.
  - A push and its matching pop occur in the same cycle.
  - fifo_write is never asserted while fifo_full=1.
  - read[i] is never asserted while empty[i]=1.
  - At most one read bit is high in any cycle.
- IDLE:
  - Scan channels in rotating order starting at rr_ptr. Pick the first channel i with empty[i]=0 and enable[i]=1.
  - If one is found: grant<=i, go to TAG. If none: stay in IDLE.
  - Arbitration costs one cycle and pushes nothing.
- TAG: when fifo_full=0, push TAG_BYTE and go to CHAN. Otherwise hold.
- CHAN: when fifo_full=0, push grant zero-extended to DATA_BITS, set count<=0, go to DATA. Otherwise hold.
- DATA, in priority order:
  - (a) If empty[grant]=1, or enable[grant]=0, or count==MAX_BURST: go to IDLE, rr_ptr<=grant+1 (wrapping to 0 after UART_COUNT-1). Nothing is pushed.
  - (b) Else if fifo_full=0: push data[grant], assert read[grant], count<=count+1. If the byte equals TAG_BYTE go to STUFF, otherwise stay in DATA.
  - (c) Else hold.
- STUFF: when fifo_full=0, push TAG_BYTE a second time and go to DATA. Otherwise hold.
  - The byte already popped is never lost.
  - The stuffed byte does not count toward MAX_BURST.
- Host decode rule:
  - TAG_BYTE followed by TAG_BYTE means a literal TAG_BYTE.
  - TAG_BYTE followed by a value below UART_COUNT means a channel switch.
- Every burst starts with a tag, including back-to-back grants of the same channel, e.g. when only one channel is active.
- An enable bit dropping mid-burst ends the burst at the next DATA decision. TAG and CHAN complete regardless, so a zero-length burst is legal.
- Reset mid-burst abandons the frame. The host resynchronises on the next tag.
- Backpressure never drops or duplicates bytes.

Test Plan:
- Single channel: ch2 FIFO holds {0x41,0x42}, all enabled, fifo_full=0 -> host receives FE,02,41,42; read[2] pulses exactly twice; busy falls 1 cycle after ch2 goes empty.
- Round robin: ch0 and ch3 each hold 20 bytes, MAX_BURST=16 -> host receives FE,00,16 bytes, then FE,03,16 bytes, then FE,00,4 bytes, then FE,03,4 bytes.
- Stuffing: ch1 holds {0xFE,0x10} -> host receives FE,01,FE,FE,10; with fifo_full=1 forced during STUFF for 5 cycles, still no loss and only one read of 0xFE.
- Backpressure: toggle fifo_full randomly over 100 bytes on ch0 -> no fifo_write while full, byte stream identical to source, push count equals pop count plus header and stuffing bytes.
- Mask: enable=4'b1101 with ch1 non-empty -> ch1 never granted; setting enable[1]=1 later serves it; clearing enable[0] mid-burst stops ch0 at the next byte boundary.
- Async reset asserted in DATA with bytes pending -> all outputs 0 at once; after release, a fresh FE,<ch> header precedes any further data.
